// File: rtl/tx_sched_pkg.sv
// Shared types and elaboration-time helpers for the TX upsampler scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  // round(out_rate * 2^acc_width / clk_freq)
  function automatic longint unsigned phase_inc_calc(input longint unsigned clk_freq,
                                                     input longint unsigned out_rate,
                                                     input int unsigned     acc_width);
    return ((out_rate << acc_width) + (clk_freq >> 1)) / clk_freq;
  endfunction

  function automatic int unsigned factor_calc(input int unsigned out_rate,
                                              input int unsigned in_rate);
    return (in_rate == 0) ? 1 : out_rate / in_rate;
  endfunction

  function automatic bit rates_ok(input int unsigned clk_freq,
                                  input int unsigned out_rate,
                                  input int unsigned in_rate);
    return (in_rate != 0) && (out_rate >= in_rate) &&
           ((out_rate % in_rate) == 0) && (out_rate < clk_freq);
  endfunction

endpackage

// File: rtl/nco_tick.sv
// Phase-accumulator NCO: the registered carry out of the accumulator is the strobe.
module nco_tick #(
  parameter int unsigned           ACC_WIDTH = 32,
  parameter logic [ACC_WIDTH-1:0]  PHASE_INC = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, PHASE_INC};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= sum[ACC_WIDTH-1:0];
      tick <= sum[ACC_WIDTH];
    end
  end

endmodule

// File: rtl/upsample_scheduler.sv
// Sequences the TX upsampler: NCO strobe, phase alignment, symbol hold register
// and zero insertion on underrun.
module upsample_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned OUT_RATE     = 6_000_000,
  parameter int unsigned IN_RATE      = 3_000_000,
  parameter int unsigned SYMBOL_WIDTH = 16,
  parameter int unsigned ACC_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    s_valid,
  input  logic [SYMBOL_WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic                    us_rst,
  output logic                    us_en,
  output logic                    us_new_sample,
  output logic [SYMBOL_WIDTH-1:0] us_sample,
  output logic                    busy,
  output logic                    underrun,
  output logic [15:0]             underrun_count
);

  localparam int unsigned          FACTOR    = factor_calc(OUT_RATE, IN_RATE);
  localparam int unsigned          PH_W      = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  localparam logic [PH_W-1:0]      PH_LAST   = PH_W'(FACTOR - 1);
  localparam logic [ACC_WIDTH-1:0] PHASE_INC =
    ACC_WIDTH'(phase_inc_calc(64'(CLK_FREQ), 64'(OUT_RATE), ACC_WIDTH));

  if (!rates_ok(CLK_FREQ, OUT_RATE, IN_RATE)) begin : g_bad_rates
    $error("upsample_scheduler: OUT_RATE must be a multiple of IN_RATE and below CLK_FREQ");
  end

  sched_state_e            state, state_next;
  logic                    tick;
  logic                    nco_clear;
  logic                    consume;
  logic                    accept;
  logic                    hold_valid;
  logic [SYMBOL_WIDTH-1:0] hold_data;
  logic [PH_W-1:0]         phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: next_state gets its default first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start && !stop)           state_next = ST_ALIGN;
      ST_ALIGN:                               state_next = ST_RUN;
      ST_RUN:   if (stop)                     state_next = ST_DRAIN;
      ST_DRAIN: if (consume && !hold_valid)   state_next = ST_IDLE;
      default:                                state_next = ST_IDLE;
    endcase
  end

  // Accumulator is held at zero through IDLE and ALIGN; the first add happens
  // on the ALIGN->RUN edge so the carry lands one cycle into RUN.
  assign nco_clear = (state_next == ST_IDLE) || (state_next == ST_ALIGN);

  nco_tick #(
    .ACC_WIDTH (ACC_WIDTH),
    .PHASE_INC (PHASE_INC)
  ) u_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (nco_clear),
    .tick  (tick)
  );

  assign consume       = tick && (phase == PH_LAST);
  assign s_ready       = (state == ST_RUN) && (!hold_valid || consume);
  assign accept        = s_valid && s_ready;
  assign underrun      = consume && !hold_valid && (state == ST_RUN);
  assign us_sample     = hold_valid ? hold_data : '0;
  assign us_new_sample = tick;
  assign busy          = (state != ST_IDLE);
  assign us_en         = (state != ST_IDLE);
  assign us_rst        = (state == ST_IDLE) || (state == ST_ALIGN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (nco_clear) begin
      phase <= '0;
    end else if (tick) begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
    end
  end

  // NOTE: hold_data is a single datapath register, not a memory, so it takes
  // the async reset along with its valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= s_data;
    end else if (consume) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_count <= '0;
    end else if ((state == ST_IDLE) && (state_next == ST_ALIGN)) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_upsample_scheduler.sv
// Self-checking bench: cycle-level behavioural model for a FACTOR=2 instance,
// directed scenarios with literal expectations, and a 100 MHz rate instance.
module tb_upsample_scheduler;

  localparam int unsigned CLK_A  = 12_000_000;
  localparam int unsigned CLK_B  = 100_000_000;
  localparam int unsigned OUT_R  = 6_000_000;
  localparam int unsigned IN_R   = 3_000_000;
  localparam int          FACT   = OUT_R / IN_R;
  localparam longint      INC_A  = (longint'(OUT_R) << 32) / longint'(CLK_A);
  localparam int          B_CYC  = 20_000;

  localparam int M_IDLE = 0, M_ALIGN = 1, M_RUN = 2, M_DRAIN = 3;

  // {busy, us_rst, us_en, us_new_sample, underrun, s_ready, us_sample, underrun_count}
  localparam logic [37:0] RESET_VEC = {6'b010000, 32'h0};

  logic        clk = 1'b0, clk_b = 1'b0;
  logic        rst_n, start, stop, s_valid;
  logic [15:0] s_data;
  logic        s_ready, us_rst, us_en, us_new_sample, busy, underrun;
  logic [15:0] us_sample, underrun_count;

  logic        rst_b_n, start_b;
  logic        s_ready_b, us_rst_b, us_en_b, us_new_sample_b, busy_b, underrun_b;
  logic [15:0] us_sample_b, underrun_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always #2 clk_b = ~clk_b;

  upsample_scheduler #(
    .CLK_FREQ(CLK_A), .OUT_RATE(OUT_R), .IN_RATE(IN_R), .SYMBOL_WIDTH(16), .ACC_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .us_rst(us_rst), .us_en(us_en), .us_new_sample(us_new_sample),
    .us_sample(us_sample), .busy(busy), .underrun(underrun),
    .underrun_count(underrun_count)
  );

  upsample_scheduler #(
    .CLK_FREQ(CLK_B), .OUT_RATE(OUT_R), .IN_RATE(IN_R), .SYMBOL_WIDTH(16), .ACC_WIDTH(32)
  ) dut_b (
    .clk(clk_b), .rst_n(rst_b_n), .start(start_b), .stop(1'b0),
    .s_valid(1'b0), .s_data(16'h0), .s_ready(s_ready_b),
    .us_rst(us_rst_b), .us_en(us_en_b), .us_new_sample(us_new_sample_b),
    .us_sample(us_sample_b), .busy(busy_b), .underrun(underrun_b),
    .underrun_count(underrun_count_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] pack_a();
    return {busy, us_rst, us_en, us_new_sample, underrun, s_ready, us_sample, underrun_count};
  endfunction

  // Reference model: strobe n of a stream is the cycle where floor((n-1)*INC/2^32) steps.
  int          m_mode = M_IDLE;
  longint      m_n = 0;
  int          m_strobes = 0;
  bit          m_held = 1'b0;
  logic [15:0] m_hdata = '0;
  int          m_cnt = 0;

  always @(negedge clk) begin : model
    bit          active, strobe, consume, ready, urun, held_pre;
    logic [15:0] samp;
    if (!rst_n) begin
      check("reset_state", pack_a(), RESET_VEC);
      m_mode = M_IDLE; m_n = 0; m_strobes = 0; m_held = 1'b0; m_hdata = '0; m_cnt = 0;
    end else begin
      active  = (m_mode == M_RUN) || (m_mode == M_DRAIN);
      strobe  = active && (m_n >= 2) &&
                (((m_n - 1) * INC_A) >> 32) > (((m_n - 2) * INC_A) >> 32);
      consume = strobe && (((m_strobes + 1) % FACT) == 0);
      samp    = m_held ? m_hdata : 16'h0;
      ready   = (m_mode == M_RUN) && (!m_held || consume);
      urun    = consume && !m_held && (m_mode == M_RUN);
      check("cycle_outputs", pack_a(),
            {m_mode != M_IDLE, m_mode <= M_ALIGN, m_mode != M_IDLE, strobe, urun, ready,
             samp, m_cnt[15:0]});
      held_pre = m_held;
      if (strobe) m_strobes++;
      if (ready && s_valid) begin
        m_held = 1'b1; m_hdata = s_data;
      end else if (consume) begin
        m_held = 1'b0;
      end
      if (urun && m_cnt < 65535) m_cnt++;
      case (m_mode)
        M_IDLE:  if (start && !stop) begin
                   m_mode = M_ALIGN; m_n = 1; m_strobes = 0; m_cnt = 0;
                 end
        M_ALIGN: begin m_mode = M_RUN; m_n++; end
        M_RUN:   begin if (stop) m_mode = M_DRAIN; m_n++; end
        default: begin if (consume && !held_pre) m_mode = M_IDLE; m_n++; end
      endcase
    end
  end

  // Behavioural zero-stuffing upsampler driven by the DUT.
  int          up_cnt = 0;
  int          ur_seen = 0;
  logic [15:0] up_q[$];
  logic [15:0] cons_q[$];

  always @(negedge clk) begin : upsampler
    if (underrun) ur_seen++;
    if (us_rst) begin
      up_cnt = 0;
    end else if (us_new_sample) begin
      if (up_cnt == FACT - 1) begin
        up_q.push_back(us_sample); cons_q.push_back(us_sample); up_cnt = 0;
      end else begin
        up_q.push_back(16'h0); up_cnt++;
      end
    end
  end

  bit last_acc, last_rdy, feed_inc;
  int n_acc;

  task automatic step();
    @(negedge clk);
    last_acc = s_valid && s_ready;
    last_rdy = s_ready;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    if (last_acc) n_acc++;
    if (last_acc && feed_inc) s_data = s_data + 16'd1;
  endtask

  task automatic run_a();
    logic [15:0] exp2 [6] = '{16'd0, 16'd1, 16'd0, 16'd2, 16'd0, 16'd3};
    int k, cons_before, rdy_drain;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0; feed_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_literal", pack_a(), RESET_VEC);
    rst_n = 1'b1;
    repeat (2) step();

    // Streaming 1,2,3 with s_valid held high
    up_q.delete(); cons_q.delete(); n_acc = 0;
    s_data = 16'd1; s_valid = 1'b1; start = 1'b1; step();
    k = 0;
    while (up_q.size() < 6 && k < 100) begin step(); k++; end
    check("t2_strobe_timeout", up_q.size() >= 6, 1);
    for (int i = 0; i < 6; i++)
      if (i < up_q.size()) check($sformatf("t2_upsampled_%0d", i), up_q[i], exp2[i]);
    check("t2_accepts", n_acc, 4);

    // Underrun across one consume strobe
    s_valid = 1'b0; k = 0;
    while (ur_seen == 0 && k < 40) begin step(); k++; end
    s_valid = 1'b1;
    check("t3_underrun_pulses", ur_seen, 1);
    check("t3_underrun_count", underrun_count, 16'd1);
    check("t3_zero_emitted", cons_q[$], 16'h0);

    // start during RUN is ignored
    repeat (3) step();
    start = 1'b1; step();
    check("t5_start_in_run", {busy, us_rst, us_en}, 3'b101);
    repeat (9) step();

    // stop with 7 in the hold register
    s_data = 16'd7; k = 0;
    step();
    while (!last_acc && k < 40) begin step(); k++; end
    check("t4_accept_7", last_acc, 1);
    cons_before = cons_q.size();
    s_data = 16'd8; stop = 1'b1; step();
    rdy_drain = last_rdy; k = 0;
    while (busy && k < 40) begin step(); k++; if (last_rdy) rdy_drain++; end
    check("t4_idle", {busy, us_rst, us_en}, 3'b010);
    check("t4_drain_consumes", cons_q.size() - cons_before, 2);
    if (cons_q.size() >= cons_before + 2) begin
      check("t4_first_drained", cons_q[cons_before], 16'd7);
      check("t4_zero_drained", cons_q[cons_before + 1], 16'd0);
    end
    check("t4_ready_in_drain", rdy_drain, 0);
    check("t4_count_kept", underrun_count, 16'd1);

    // Restart clears the count; stop in ALIGN is ignored
    s_valid = 1'b0; start = 1'b1; step();
    check("t3_restart_align", {busy, us_rst, us_en, underrun_count}, {3'b111, 16'd0});
    stop = 1'b1; step();
    check("t5_stop_in_align", {busy, us_rst}, 2'b10);
    stop = 1'b1; step(); k = 0;
    while (busy && k < 40) begin step(); k++; end
    check("t5_drain_empty_idle", busy, 0);

    start = 1'b1; stop = 1'b1; step();
    check("t5_start_stop_idle", {busy, us_rst}, 2'b01);

    // Asynchronous reset mid-stream
    s_valid = 1'b1; s_data = 16'h00A5; start = 1'b1; step();
    repeat (12) step();
    #2 rst_n = 1'b0;
    #1 check("t1_async_reset", pack_a(), RESET_VEC);
    step();
    rst_n = 1'b1;

    // Randomised traffic against the model
    feed_inc = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 16'($urandom);
      start   = ($urandom_range(0, 39) == 0);
      stop    = ($urandom_range(0, 59) == 0);
      step();
    end
  endtask

  task automatic run_b();
    int last = -1;
    int strobes = 0;
    int bad = 0;
    int exp_cnt;
    exp_cnt = int'((longint'(B_CYC) * OUT_R) / CLK_B);
    rst_b_n = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk_b);
    #1 rst_b_n = 1'b1;
    @(posedge clk_b); #1 start_b = 1'b1;
    @(posedge clk_b); #1 start_b = 1'b0;
    for (int c = 0; c < B_CYC; c++) begin
      @(negedge clk_b);
      if (us_new_sample_b) begin
        strobes++;
        if (last >= 0 && (c - last != 16) && (c - last != 17)) bad++;
        last = c;
      end
    end
    check("b_spacing_outside_16_17", bad, 0);
    check("b_strobe_count_within_1", (strobes >= exp_cnt - 1) && (strobes <= exp_cnt + 1), 1);
    check("b_running", {busy_b, us_rst_b, us_en_b}, 3'b101);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
